// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: I-cache block fill and write-through store initiator
// for a 16-bit byte-addressed single-cycle memory.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   miss_req/addr     cache miss request (level) and faulting byte address
//   fill_busy/done    fill in progress / one-cycle block-installed pulse
//   cache_we/word/wdata  data-array word write
//   tag_we/tag_out    tag-array write and block address
//   st_req/addr/data  pipeline store request (level until acked)
//   st_ack            store performed this cycle
//   mem_*             memory port (combinational read, posedge write)
module icache_fill_ctrl #(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WORDS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      miss_req,
  input  logic [ADDR_WIDTH-1:0]     miss_addr,
  output logic                      fill_busy,
  output logic                      fill_done,
  output logic                      cache_we,
  output logic [$clog2(BLOCK_WORDS)-1:0] cache_word,
  output logic [15:0]               cache_wdata,
  output logic                      tag_we,
  output logic [ADDR_WIDTH-$clog2(BLOCK_WORDS)-2:0] tag_out,
  input  logic                      st_req,
  input  logic [ADDR_WIDTH-1:0]     st_addr,
  input  logic [15:0]               st_data,
  output logic                      st_ack,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic                      mem_enable,
  output logic                      mem_wr,
  output logic [15:0]               mem_wdata,
  input  logic [15:0]               mem_rdata
);

  localparam int CW       = $clog2(BLOCK_WORDS);
  localparam int OFF_BITS = CW + 1;
  localparam int BW       = ADDR_WIDTH - OFF_BITS;

  localparam logic [CW-1:0] LAST = CW'(BLOCK_WORDS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] TAG  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] blk_reg;
  logic [BW-1:0] miss_blk;

  // Cast of the shifted address keeps every miss_addr bit referenced.
  assign miss_blk = BW'(miss_addr >> OFF_BITS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      blk_reg <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (miss_req) begin
            blk_reg <= miss_blk;
            cnt     <= '0;
            state   <= FILL;
          end
        end
        FILL: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= TAG;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TAG:     state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are held at zero during reset so the memory can be loaded.
  always_comb begin
    fill_busy   = 1'b0;
    fill_done   = 1'b0;
    cache_we    = 1'b0;
    cache_word  = '0;
    cache_wdata = '0;
    tag_we      = 1'b0;
    tag_out     = '0;
    st_ack      = 1'b0;
    mem_addr    = '0;
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    mem_wdata   = '0;
    if (!rst) begin
      cache_word = cnt;
      tag_out    = blk_reg;
      unique case (state)
        IDLE: begin
          if (st_req) begin
            st_ack     = 1'b1;
            mem_enable = 1'b1;
            mem_wr     = 1'b1;
            mem_addr   = st_addr & ~ADDR_WIDTH'(1);
            mem_wdata  = st_data;
          end
        end
        FILL: begin
          fill_busy   = 1'b1;
          mem_enable  = 1'b1;
          mem_addr    = {blk_reg, cnt, 1'b0};
          cache_we    = 1'b1;
          cache_wdata = mem_rdata;
        end
        TAG: begin
          fill_busy = 1'b1;
          tag_we    = 1'b1;
        end
        DONE: begin
          fill_busy = 1'b1;
          fill_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// tb_icache_fill_ctrl: directed bench for icache_fill_ctrl
// with a behavioural single-cycle memory.
module tb_icache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_req;
  logic [15:0] miss_addr;
  logic        fill_busy;
  logic        fill_done;
  logic        cache_we;
  logic [2:0]  cache_word;
  logic [15:0] cache_wdata;
  logic        tag_we;
  logic [11:0] tag_out;
  logic        st_req;
  logic [15:0] st_addr;
  logic [15:0] st_data;
  logic        st_ack;
  logic [15:0] mem_addr;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [0:32767];
  logic [15:0] exp_blk [8];

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[15:1]];

  always @(posedge clk)
    if (mem_enable && mem_wr)
      mem[mem_addr[15:1]] <= mem_wdata;

  icache_fill_ctrl dut (
    .clk(clk), .rst(rst),
    .miss_req(miss_req), .miss_addr(miss_addr),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .cache_we(cache_we), .cache_word(cache_word),
    .cache_wdata(cache_wdata),
    .tag_we(tag_we), .tag_out(tag_out),
    .st_req(st_req), .st_addr(st_addr),
    .st_data(st_data), .st_ack(st_ack),
    .mem_addr(mem_addr), .mem_enable(mem_enable),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    string       nm;
    logic        r;
    logic        m;
    logic [15:0] ma;
    logic        s;
    logic [15:0] sa;
    logic [15:0] sd;
    logic [69:0] ex;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [69:0] o(
    input logic b, d, cw, input logic [2:0] wi,
    input logic [15:0] cd, input logic tw,
    input logic [11:0] to, input logic ak, en, wr,
    input logic [15:0] ma, wd);
    return {b, d, cw, wi, cd, tw, to, ak, en, wr, ma, wd};
  endfunction

  function automatic logic [69:0] obs();
    return {fill_busy, fill_done, cache_we, cache_word,
            cache_wdata, tag_we, tag_out, st_ack,
            mem_enable, mem_wr, mem_addr, mem_wdata};
  endfunction

  function automatic vec_t mkv(input string nm,
    input logic r, m, input logic [15:0] ma,
    input logic s, input logic [15:0] sa, sd,
    input logic [69:0] ex);
    vec_t v;
    v.nm = nm; v.r = r; v.m = m; v.ma = ma;
    v.s = s; v.sa = sa; v.sd = sd; v.ex = ex;
    return v;
  endfunction

  task automatic chk(input string nm,
    input logic [69:0] got, input logic [69:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_miss(input string nm,
    input logic [15:0] a);
    miss_req  = 1'b1;
    miss_addr = a;
    @(negedge clk);
    chk({nm, "_idle_busy"}, 70'(fill_busy), 70'(0));
    tick();
  endtask

  // Checks FILL, TAG and DONE; miss held high through DONE.
  task automatic fill_seq(input string nm,
    input logic [15:0] base, input int st_at);
    logic [11:0] t;
    t = base[15:4];
    for (int k = 0; k < 8; k++) begin
      if (k == st_at) st_req = 1'b1;
      @(negedge clk);
      chk($sformatf("%s_fill%0d", nm, k), obs(),
          o(1, 0, 1, 3'(k), exp_blk[k], 0, t, 0, 1, 0,
            base + 16'(2 * k), 16'h0));
      tick();
    end
    @(negedge clk);
    chk({nm, "_tag"}, obs(),
        o(1, 0, 0, 3'd0, 16'h0, 1, t, 0, 0, 0, 16'h0, 16'h0));
    tick();
    @(negedge clk);
    chk({nm, "_done"}, obs(),
        o(1, 1, 0, 3'd0, 16'h0, 0, t, 0, 0, 0, 16'h0, 16'h0));
    tick();
    miss_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32768; i++)
      mem[i] = 16'hC000 ^ 16'(i);
    for (int k = 0; k < 8; k++) begin
      mem[16'h0020 + k] = 16'hA000 + 16'(k);
      mem[16'h7FF8 + k] = 16'hF000 + 16'(k);
    end

    rst = 1'b1; miss_req = 1'b0; miss_addr = '0;
    st_req = 1'b0; st_addr = '0; st_data = '0;

    tbl.push_back(mkv("rst0", 1, 1, 16'h0046, 1, 16'h1235,
      16'hBEEF, 70'(0)));
    tbl.push_back(mkv("rst1", 1, 1, 16'h0046, 1, 16'h1235,
      16'hBEEF, 70'(0)));
    tbl.push_back(mkv("idle", 0, 0, 16'h0, 0, 16'h0,
      16'h0, 70'(0)));
    tbl.push_back(mkv("store", 0, 0, 16'h0, 1, 16'h1235,
      16'hBEEF,
      o(0, 0, 0, 3'd0, 16'h0, 0, 12'h0, 1, 1, 1,
        16'h1234, 16'hBEEF)));
    tbl.push_back(mkv("miss_acc", 0, 1, 16'h0046, 0, 16'h0,
      16'h0, 70'(0)));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mkv($sformatf("fill%0d", k), 0, 1,
        16'h0046, 0, 16'h0, 16'h0,
        o(1, 0, 1, 3'(k), 16'hA000 + 16'(k), 0, 12'h004,
          0, 1, 0, 16'h0040 + 16'(2 * k), 16'h0)));
    tbl.push_back(mkv("tag", 0, 1, 16'h0046, 0, 16'h0, 16'h0,
      o(1, 0, 0, 3'd0, 16'h0, 1, 12'h004, 0, 0, 0,
        16'h0, 16'h0)));
    tbl.push_back(mkv("done", 0, 1, 16'h0046, 0, 16'h0, 16'h0,
      o(1, 1, 0, 3'd0, 16'h0, 0, 12'h004, 0, 0, 0,
        16'h0, 16'h0)));
    tbl.push_back(mkv("idle2", 0, 0, 16'h0, 0, 16'h0, 16'h0,
      o(0, 0, 0, 3'd0, 16'h0, 0, 12'h004, 0, 0, 0,
        16'h0, 16'h0)));

    foreach (tbl[i]) begin
      rst       = tbl[i].r;
      miss_req  = tbl[i].m;
      miss_addr = tbl[i].ma;
      st_req    = tbl[i].s;
      st_addr   = tbl[i].sa;
      st_data   = tbl[i].sd;
      @(negedge clk);
      chk(tbl[i].nm, obs(), tbl[i].ex);
      tick();
    end

    // Read back the earlier store through a fill of 0x1230.
    for (int k = 0; k < 8; k++)
      exp_blk[k] = 16'hC000 ^ (16'h0918 + 16'(k));
    exp_blk[2] = 16'hBEEF;
    start_miss("rdback", 16'h1234);
    fill_seq("rdback", 16'h1230, -1);

    // Store raised mid-fill stalls until IDLE.
    for (int k = 0; k < 8; k++)
      exp_blk[k] = 16'hA000 + 16'(k);
    st_addr = 16'h0042;
    st_data = 16'h1111;
    start_miss("stfill", 16'h0040);
    fill_seq("stfill", 16'h0040, 3);
    @(negedge clk);
    chk("stfill_ack", obs(),
        o(0, 0, 0, 3'd0, 16'h0, 0, 12'h004, 1, 1, 1,
          16'h0042, 16'h1111));
    tick();
    st_req = 1'b0;

    // Store and miss in the same IDLE cycle.
    st_req = 1'b1; st_addr = 16'h0044; st_data = 16'h5555;
    miss_req = 1'b1; miss_addr = 16'h0040;
    @(negedge clk);
    chk("both_ack", obs(),
        o(0, 0, 0, 3'd0, 16'h0, 0, 12'h004, 1, 1, 1,
          16'h0044, 16'h5555));
    tick();
    st_req = 1'b0;
    exp_blk[1] = 16'h1111;
    exp_blk[2] = 16'h5555;
    fill_seq("both", 16'h0040, -1);

    // Reset in fill cycle 4 aborts the fill.
    start_miss("rstfill", 16'h0040);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rstfill_fill%0d", k), obs(),
          o(1, 0, 1, 3'(k), exp_blk[k], 0, 12'h004, 0, 1, 0,
            16'h0040 + 16'(2 * k), 16'h0));
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rstfill_inrst", obs(), 70'(0));
    tick();
    rst = 1'b0;
    miss_req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("rstfill_idle%0d", c), obs(), 70'(0));
      tick();
    end
    start_miss("refill", 16'h0040);
    fill_seq("refill", 16'h0040, -1);

    // Top-of-memory block, miss held through DONE.
    for (int k = 0; k < 8; k++)
      exp_blk[k] = 16'hF000 + 16'(k);
    start_miss("top", 16'hFFFA);
    fill_seq("top", 16'hFFF0, -1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("top_idle%0d", c), obs(),
          o(0, 0, 0, 3'd0, 16'h0, 0, 12'hFFF, 0, 0, 0,
            16'h0, 16'h0));
      tick();
    end

    // A miss still high in IDLE starts a new fill.
    for (int k = 0; k < 8; k++)
      exp_blk[k] = 16'hA000 + 16'(k);
    exp_blk[1] = 16'h1111;
    exp_blk[2] = 16'h5555;
    start_miss("again", 16'h004E);
    fill_seq("again", 16'h0040, -1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_fill_ctrl.md
Name: icache_fill_ctrl

Overview:
Memory-side initiator for the 16-bit byte-addressable single-cycle memory (combinational read, posedge write, no concurrent read/write). On an I-cache miss it reads the whole aligned block word-by-word, streams each word into the cache data array, then writes the tag. It also issues single-cycle write-through stores from the pipeline, arbitrating them against fills.

Parameters:
ADDR_WIDTH, 16, byte-address width; matches the memory's address width.
BLOCK_WORDS, 8, 16-bit words per cache block; power of 2, >=2.
OFF_BITS (localparam), $clog2(BLOCK_WORDS)+1, byte-offset bits within a block (4 at default).

Ports:
clk  in  1  clock; all state changes on posedge.
rst  in  1  reset, synchronous, active-high.
miss_req  in  1  cache miss; level, may stay high until fill_done.
miss_addr  in  ADDR_WIDTH  faulting byte address.
fill_busy  out  1  high in FILL, TAG and DONE.
fill_done  out  1  one-cycle pulse when the block is installed.
cache_we  out  1  data-array word write enable.
cache_word  out  $clog2(BLOCK_WORDS)  word index within the block.
cache_wdata  out  16  word to write into the data array.
tag_we  out  1  tag-array write enable.
tag_out  out  ADDR_WIDTH-OFF_BITS  block address to install (miss_addr[ADDR_WIDTH-1:OFF_BITS]).
st_req  in  1  store request; level, held until acked.
st_addr  in  ADDR_WIDTH  store byte address; bit 0 is ignored (forced 0 on mem_addr).
st_data  in  16  store data.
st_ack  out  1  store performed this cycle.
mem_addr  out  ADDR_WIDTH  memory address; bit 0 is always 0.
mem_enable  out  1  memory enable.
mem_wr  out  1  memory write.
mem_wdata  out  16  memory write data.
mem_rdata  in  16  memory read data; valid in the same cycle as enable & ~wr.

Behaviour:
- States: IDLE, FILL, TAG, DONE. blk_reg holds the latched block address; cnt is the word counter.
- Outputs are combinational from state, cnt, blk_reg and the store inputs. They carry no extra register stage.
- Reset (rst=1 at posedge): state=IDLE, cnt=0, blk_reg=0.
  - While rst is high, all outputs are 0, including mem_enable=0 and st_ack=0, so the memory can load its image.
  - Reset mid-fill aborts the fill: no tag_we and no fill_done; the partial block stays invalid.
- IDLE, store path:
  - If st_req=1: st_ack=1, mem_enable=1, mem_wr=1, mem_addr={st_addr[ADDR_WIDTH-1:1],0}, mem_wdata=st_data.
  - A store is performed once per acked cycle. The requester drops st_req after seeing ack.
- IDLE, miss path:
  - If miss_req=1: latch blk_reg=miss_addr[ADDR_WIDTH-1:OFF_BITS], cnt=0, and go to FILL.
  - A store and a miss in the same IDLE cycle are both accepted. The store writes in that cycle and the fill starts next cycle, so the fill returns the stored data.
- FILL (BLOCK_WORDS cycles):
  - mem_enable=1, mem_wr=0, mem_addr={blk_reg,cnt,1'b0}.
  - cache_we=1, cache_word=cnt, cache_wdata=mem_rdata.
  - cnt increments each cycle. When cnt==BLOCK_WORDS-1: cnt wraps to 0 and the state goes to TAG.
- TAG (1 cycle): tag_we=1, tag_out=blk_reg, mem_enable=0, then go to DONE.
- DONE (1 cycle): fill_done=1; miss_req is ignored; go to IDLE.
  - This absorbs the one-cycle lag of the stale miss signal, so no refetch occurs.
- Latency: miss_req seen in IDLE at cycle N -> FILL N+1..N+BLOCK_WORDS -> TAG N+BLOCK_WORDS+1 -> DONE N+BLOCK_WORDS+2 -> IDLE. That is 11 cycles at the default.
- st_ack=0 in FILL, TAG and DONE; stores stall until IDLE.
- miss_addr changes after acceptance are ignored.
- Idle defaults: outputs not driven above are 0. tag_out=blk_reg and cache_word=cnt at all times.
- Block address wrap: blk_reg all-ones fills the top block (0xFFF0-0xFFFE at default) with no overflow.

Test Plan:
1. Basic fill.
   - Stimulus: memory word at 0x0040+2k = 0xA000+k; miss_req=1 with miss_addr=0x0046.
   - Required: mem_addr 0x0040, 0x0042, ..., 0x004E over 8 cycles with cache_word 0..7 and cache_wdata 0xA000..0xA007.
   - Then tag_we=1 with tag_out=0x004, then fill_done for one cycle. Total is 11 cycles.
2. Store in IDLE.
   - Stimulus: st_req=1, st_addr=0x1235, st_data=0xBEEF.
   - Required: same-cycle st_ack=1, mem_wr=1, mem_addr=0x1234. A later read of 0x1234 returns 0xBEEF.
3. Store during fill.
   - Stimulus: assert st_req at fill cycle 3.
   - Required: st_ack=0 through FILL, TAG and DONE; ack in the first IDLE cycle. The fill data is unchanged.
4. Simultaneous store and miss.
   - Stimulus: st_addr=0x0044, st_data=0x5555, miss_addr=0x0040, both in the same IDLE cycle.
   - Required: store acked that cycle; fill word 2 = 0x5555.
5. Reset at fill cycle 4.
   - Required: next cycle all outputs 0 and state IDLE; tag_we and fill_done never assert.
   - A new miss then refills from word 0.
6. Top-of-memory block with miss_req held high through DONE.
   - Stimulus: miss_addr=0xFFFA, miss_req held through DONE.
   - Required: addresses 0xFFF0..0xFFFE, tag_out=0xFFF. Exactly one fill occurs, then IDLE; a new fill starts only if miss_req is still high in IDLE.
